// File: rtl/up_down_counter.sv
// Modulo-2^WIDTH up/down counter with count enable, synchronous active-high clear and roll-over pulse.
// One-cycle latency from inputs to the registered count/wrap outputs; no handshake or backpressure.
module up_down_counter #(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             up_down,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;

  // Roll-over is detected from the current value, so wrap lines up with the cycle the new count appears.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (enable) begin
      if (up_down) begin
        count_next = count + COUNT_ONE;
        wrap_next  = (count == COUNT_MAX);
      end else begin
        count_next = count - COUNT_ONE;
        wrap_next  = (count == '0);
      end
    end
  end

  // reset_n is active-high despite its name: 1 clears the counter.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      count <= RESET_VALUE;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

endmodule

// File: tb/tb_up_down_counter.sv
// Directed bench for up_down_counter (WIDTH=4): hand-derived count/wrap expectations per cycle.
module tb_up_down_counter;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       up_down;
  logic [3:0] count;
  logic       wrap;

  int checks;
  int failures;
  int wraps_seen;

  up_down_counter #(
    .WIDTH      (4),
    .RESET_VALUE(4'd0)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .enable (enable),
    .up_down(up_down),
    .count  (count),
    .wrap   (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int exp_count, input int exp_wrap);
    check($sformatf("%s_count", tag), 32'(count), 32'(exp_count));
    check($sformatf("%s_wrap", tag), 32'(wrap), 32'(exp_wrap));
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    wraps_seen = 0;
    reset_n    = 1'b1;
    enable     = 1'b1;
    up_down    = 1'b1;

    // Reset with enable/up_down active: reset must win.
    step();
    expect_state("reset", 0, 0);
    reset_n = 1'b0;
    enable  = 1'b0;
    step();
    expect_state("release_hold", 0, 0);

    // Enable gating.
    up_down = 1'b1;
    enable  = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      expect_state($sformatf("gate_off%0d", i), 0, 0);
    end
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      expect_state($sformatf("gate_on%0d", i), i, 0);
    end
    enable = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_state($sformatf("gate_hold%0d", i), 5, 0);
    end

    // Up wrap from 5: 15->0 happens on the 11th step.
    enable     = 1'b1;
    up_down    = 1'b1;
    wraps_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (wrap === 1'b1) wraps_seen++;
      expect_state($sformatf("up%0d", i), (5 + i) % 16, (i == 11) ? 1 : 0);
    end
    check("up_end_count", 32'(count), 32'd9);
    check("up_wrap_pulses", 32'(wraps_seen), 32'd1);

    // Down wrap from 9: 0->15 happens on the 10th step.
    up_down    = 1'b0;
    wraps_seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (wrap === 1'b1) wraps_seen++;
      expect_state($sformatf("down%0d", i), (9 - i + 32) % 16, (i == 10) ? 1 : 0);
    end
    check("down_end_count", 32'(count), 32'd5);
    check("down_wrap_pulses", 32'(wraps_seen), 32'd1);

    // Reset mid-count while enabled.
    up_down = 1'b1;
    step();
    expect_state("pre_reset", 6, 0);
    reset_n = 1'b1;
    step();
    expect_state("mid_reset", 0, 0);
    reset_n = 1'b0;
    enable  = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      step();
      expect_state($sformatf("post_reset%0d", i), 0, 0);
    end

    // Direction toggles every cycle: 1,0,1,0 with no wrap.
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      up_down = (i % 2 == 1) ? 1'b1 : 1'b0;
      step();
      expect_state($sformatf("toggle%0d", i), (i % 2 == 1) ? 1 : 0, 0);
    end

    // Wrap pulse followed by hold must drop wrap while count holds at 15.
    up_down = 1'b0;
    step();
    expect_state("down_from0", 15, 1);
    enable = 1'b0;
    step();
    expect_state("hold_after_wrap", 15, 0);

    // Reset at max while an up-wrap is requested: reset wins, no wrap.
    enable  = 1'b1;
    up_down = 1'b1;
    reset_n = 1'b1;
    step();
    expect_state("reset_vs_wrap", 0, 0);
    reset_n = 1'b0;
    step();
    expect_state("count_after_reset", 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
